// File: rtl/ram_loader.sv
// Host-side loader: pushes a reset/config/write/verify/run command stream to a byte device
// over a four-phase valid/ready link, sourcing payload bytes from a byte memory.
module ram_loader #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            verify_en_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] size_i,
  input  logic [XLEN-1:0] wr_len_i,
  input  logic [XLEN-1:0] rd_len_i,
  output logic            src_rd_en_o,
  output logic [XLEN-1:0] src_addr_o,
  input  logic [7:0]      src_data_i,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_data_vld_o,
  input  logic            uart_tx_data_rdy_i,
  input  logic [7:0]      uart_rx_data_i,
  input  logic            uart_rx_data_vld_i,
  output logic            uart_rx_data_rdy_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [15:0]     err_cnt_o
);

  localparam int unsigned WdW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StIdle, StRstCmd, StCfgCmd, StCfgDat, StWrCmd, StWrFetch, StWrDat,
    StRdCmd, StRdDat, StRunCmd, StDone, StAbort
  } state_e;

  typedef enum logic [2:0] {PhSend, PhWait, PhLoad, PhFetch, PhRecv} phase_e;

  state_e          state_q, state_d, wr_next;
  phase_e          tph_q, tph_d;
  logic [XLEN-1:0] idx_q, idx_d;
  logic [XLEN-1:0] addr_q, addr_d, size_q, size_d;
  logic [XLEN-1:0] wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic            verify_q, verify_d;
  logic [7:0]      byte_q, byte_d, exp_q, exp_d, rx_byte_q;
  logic            err_q, err_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            rx_vld_q, rx_ack_q, rx_pend_q, rx_pend_clr, rx_rise;
  logic            tx_active, byte_fin, waiting;
  logic [7:0]      tx_byte;
  logic [63:0]     cfg_word;

  assign cfg_word = {size_q[31:0], addr_q[31:0]};
  assign rx_rise  = uart_rx_data_vld_i & ~rx_vld_q;

  assign uart_rx_data_rdy_o = rx_ack_q && (state_q != StAbort);
  assign busy_o             = (state_q != StIdle);
  assign done_o             = (state_q == StDone);
  assign err_o              = err_q;
  assign err_cnt_o          = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    tph_d       = tph_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wr_len_d    = wr_len_q;
    rd_len_d    = rd_len_q;
    verify_d    = verify_q;
    byte_d      = byte_q;
    exp_d       = exp_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    rx_pend_clr = 1'b0;
    tx_active   = 1'b0;
    tx_byte     = 8'h00;
    byte_fin    = 1'b0;
    waiting     = 1'b0;
    src_rd_en_o = 1'b0;
    src_addr_o  = '0;
    wr_next     = verify_q ? StRdCmd : StRunCmd;

    case (state_q)
      StRstCmd: begin tx_active = 1'b1; tx_byte = 8'h2A; end
      StCfgCmd: begin tx_active = 1'b1; tx_byte = 8'h2C; end
      StCfgDat: begin tx_active = 1'b1; tx_byte = cfg_word[{idx_q[2:0], 3'b000} +: 8]; end
      StWrCmd:  begin tx_active = 1'b1; tx_byte = 8'h2E; end
      StWrDat:  begin tx_active = (tph_q != PhLoad); tx_byte = byte_q; end
      StRdCmd:  begin tx_active = 1'b1; tx_byte = 8'h2F; end
      // With any readback mismatch the run command is withheld and the CPU stays in reset.
      StRunCmd: begin tx_active = (err_cnt_q == '0); tx_byte = 8'h2B; end
      default:  ;
    endcase

    if (tx_active) begin
      waiting = 1'b1;
      if (tph_q == PhSend && uart_tx_data_rdy_i) begin
        tph_d = PhWait;
      end else if (tph_q == PhWait && !uart_tx_data_rdy_i) begin
        byte_fin = 1'b1;
      end
    end
    uart_tx_data_vld_o = tx_active && (tph_q == PhSend);
    uart_tx_data_o     = tx_active ? tx_byte : 8'h00;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d    = addr_i;
          size_d    = size_i;
          wr_len_d  = wr_len_i;
          rd_len_d  = rd_len_i;
          verify_d  = verify_en_i;
          err_d     = 1'b0;
          err_cnt_d = '0;
          idx_d     = '0;
          tph_d     = PhSend;
          state_d   = StRstCmd;
        end
      end
      StRstCmd: if (byte_fin) begin state_d = StCfgCmd; tph_d = PhSend; end
      StCfgCmd: if (byte_fin) begin state_d = StCfgDat; tph_d = PhSend; idx_d = '0; end
      StCfgDat: begin
        if (byte_fin) begin
          tph_d = PhSend;
          if (idx_q[2:0] == 3'd7) begin
            state_d = StWrCmd;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + XLEN'(1);
          end
        end
      end
      StWrCmd: begin
        if (byte_fin) begin
          idx_d = '0;
          tph_d = PhSend;
          state_d = (wr_len_q == '0) ? wr_next : StWrFetch;
        end
      end
      StWrFetch: begin
        src_rd_en_o = 1'b1;
        src_addr_o  = idx_q;
        tph_d       = PhLoad;
        state_d     = StWrDat;
      end
      StWrDat: begin
        if (tph_q == PhLoad) begin
          byte_d = src_data_i;
          tph_d  = PhSend;
        end else if (byte_fin) begin
          if (idx_q + XLEN'(1) == wr_len_q) begin
            idx_d   = '0;
            tph_d   = PhSend;
            state_d = wr_next;
          end else begin
            idx_d   = idx_q + XLEN'(1);
            state_d = StWrFetch;
          end
        end
      end
      StRdCmd: begin
        if (byte_fin) begin
          idx_d = '0;
          if (rd_len_q == '0) begin
            state_d = StRunCmd;
            tph_d   = PhSend;
          end else begin
            state_d = StRdDat;
            tph_d   = PhFetch;
          end
        end
      end
      StRdDat: begin
        case (tph_q)
          PhFetch: begin
            src_rd_en_o = 1'b1;
            src_addr_o  = idx_q;
            tph_d       = PhLoad;
          end
          PhLoad: begin
            exp_d = src_data_i;
            tph_d = PhRecv;
          end
          PhRecv: begin
            waiting = 1'b1;
            if (rx_pend_q) begin
              rx_pend_clr = 1'b1;
              if (rx_byte_q != exp_q) begin
                err_d = 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
              end
              if (idx_q + XLEN'(1) == rd_len_q) begin
                idx_d   = '0;
                tph_d   = PhSend;
                state_d = StRunCmd;
              end else begin
                idx_d = idx_q + XLEN'(1);
                tph_d = PhFetch;
              end
            end
          end
          default: tph_d = PhFetch;
        endcase
      end
      StRunCmd: if (err_cnt_q != '0 || byte_fin) state_d = StDone;
      StDone:   state_d = StIdle;
      StAbort:  state_d = StDone;
      default:  state_d = StIdle;
    endcase

    // A handshake phase that has not advanced for TIMEOUT cycles is abandoned.
    if (waiting && state_d == state_q && tph_d == tph_q && wd_q == WdW'(TIMEOUT - 1)) begin
      state_d = StAbort;
      err_d   = 1'b1;
    end

    wd_d = (state_q == StIdle || state_d != state_q || tph_d != tph_q) ? '0 : wd_q + WdW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      tph_q     <= PhSend;
      idx_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      wr_len_q  <= '0;
      rd_len_q  <= '0;
      verify_q  <= 1'b0;
      byte_q    <= '0;
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      wd_q      <= '0;
      rx_vld_q  <= 1'b0;
      rx_ack_q  <= 1'b0;
      rx_pend_q <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      tph_q     <= tph_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wr_len_q  <= wr_len_d;
      rd_len_q  <= rd_len_d;
      verify_q  <= verify_d;
      byte_q    <= byte_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      wd_q      <= wd_d;
      rx_vld_q  <= uart_rx_data_vld_i;
      if (rx_rise) begin
        rx_ack_q <= 1'b1;
      end else if (!uart_rx_data_vld_i) begin
        rx_ack_q <= 1'b0;
      end
      // Responses outside readback are acknowledged but never queued for comparison.
      if (rx_rise && state_q == StRdDat) begin
        rx_pend_q <= 1'b1;
        rx_byte_q <= uart_rx_data_i;
      end else if (rx_pend_clr || state_q == StIdle) begin
        rx_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/size/count width.
REQ-002 SHALL have parameter TIMEOUT, default 1_000_000, cycles allowed per handshake phase before abort.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  level; sampled only in IDLE, starts one load sequence.
REQ-006 verify_en_i  input  1  sampled with start_i; enables readback phase.
REQ-007 addr_i / size_i  input  XLEN each  values sent in CONF_WR payload; captured at start.
REQ-008 wr_len_i / rd_len_i  input  XLEN each  byte counts of DATA_WR payload / DATA_RD response; captured at start.
REQ-009 src_rd_en_o  output  1  one-cycle read strobe to source byte memory.
REQ-010 src_addr_o  output  XLEN  source byte offset, 0-based.
REQ-011 src_data_i  input  8  source byte, valid 1 cycle after src_rd_en_o.
REQ-012 uart_tx_data_o  output  8  byte to the device.
REQ-013 uart_tx_data_vld_o  output  1  byte valid.
REQ-014 uart_tx_data_rdy_i  input  1  device acknowledge.
REQ-015 uart_rx_data_i  input  8  response byte from the device.
REQ-016 uart_rx_data_vld_i  input  1  response valid.
REQ-017 uart_rx_data_rdy_o  output  1  response acknowledge.
REQ-018 busy_o / done_o / err_o  output  1 each  sequence active / one-cycle completion pulse / sticky failure.
REQ-019 err_cnt_o  output  16  readback mismatch count, saturating.

Function
REQ-020 Byte send SHALL be four-phase: drive data and vld=1; hold until rdy_i=1; drop vld; wait rdy_i=0; data stable throughout.
REQ-021 vld_o SHALL stay low at least 1 cycle between bytes.
REQ-022 Byte receive: rising edge of rx_vld_i (registered edge detect) captures rx_data_i; rdy_o=1 from the next cycle until rx_vld_i=0.
REQ-023 FSM states: IDLE, RST_CMD, CFG_CMD, CFG_DAT, WR_CMD, WR_FETCH, WR_DAT, RD_CMD, RD_DAT, RUN_CMD, DONE, ABORT.
REQ-024 IDLE->RST_CMD on start_i=1; inputs latched; err_o, err_cnt_o cleared same cycle.
REQ-025 RST_CMD sends 0x2A; CFG_CMD sends 0x2C; CFG_DAT sends 8 bytes: addr[7:0]..addr[31:24], size[7:0]..size[31:24].
REQ-026 WR_CMD sends 0x2E; if wr_len=0 skips payload, next phase directly.
REQ-027 WR_FETCH pulses src_rd_en_o with src_addr_o=byte index; WR_DAT sends src_data_i captured next cycle; repeats wr_len times, index 0..wr_len-1.
REQ-028 After write: verify_en latched=1 -> RD_CMD, else RUN_CMD.
REQ-029 RD_CMD sends 0x2F; RD_DAT receives rd_len bytes; each compared with source byte at same index (fetch issued before expected arrival); mismatch -> err_cnt_o+1 (saturate 0xFFFF), err_o=1.
REQ-030 RUN_CMD sends 0x2B only if err_cnt_o=0; otherwise skip to DONE with CPU left in reset.
REQ-031 DONE: done_o=1 one cycle, then IDLE; busy_o=1 in every state except IDLE.
REQ-032 Watchdog counter reloads on every handshake phase change; reaching TIMEOUT -> ABORT: err_o=1, vld_o=0, rdy_o=0, then DONE.
REQ-033 start_i while busy SHALL be ignored.
REQ-034 Byte index counters XLEN wide; wr_len/rd_len up to 2^XLEN-1 without wrap.
REQ-035 Response bytes arriving outside RD_DAT SHALL be acknowledged and discarded.

Reset
REQ-036 rst_n_i=0 at any time: state IDLE, all outputs 0 (tx_data 0x00, err_cnt 0), counters 0; takes effect immediately, no partial byte completed.

Verification
REQ-037 addr=0x0000_1000, size=3, wr_len=4, verify off, source 11 22 33 44 -> device sees 2A 2C 00 10 00 00 03 00 00 00 2E 11 22 33 44 2B; one done pulse; err_o=0.
REQ-038 Same with verify on, rd_len=4, device echoes 11 22 33 44 -> 2F sent, err_cnt_o=0, 2B sent, done.
REQ-039 Verify on, echo 11 22 00 44 -> err_cnt_o=1, err_o=1, no 2B sent, done pulse.
REQ-040 Device holds rdy_i=0, TIMEOUT=16 -> ABORT after 16 cycles, vld_o=0, err_o=1, done pulse.
REQ-041 wr_len=0 -> no src_rd_en_o pulses, 2E directly followed by 2B.
REQ-042 rst_n_i asserted mid-WR_DAT -> all outputs 0 within same cycle; fresh start_i yields full sequence from 2A.
